// File: rtl/acc_pkg.sv
// acc_pkg: shared sizing, FSM encoding and in-flight tag layout for the cube sequencer
package acc_pkg;

    localparam int ACC_DEPTH = 16;
    localparam int ACC_IW    = $clog2(ACC_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_DRAIN,
        CU_ISSUE,
        CU_DRAIN
    } acc_state_t;

    // Which pass an in-flight product belongs to, i.e. where its result lands
    typedef enum logic {
        PASS_SQ,
        PASS_CU
    } acc_pass_t;

    typedef struct packed {
        logic              valid;
        acc_pass_t         pass;
        logic [ACC_IW-1:0] idx;
    } acc_tag_t;

endpackage

// File: rtl/acc_tag_pipe.sv
// acc_tag_pipe: MUL_LAT-deep delay line that tracks each issued multiply until its product returns
module acc_tag_pipe
    import acc_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  acc_tag_t tag_in,
    output acc_tag_t tag_out
);

    acc_tag_t stage [MUL_LAT];

    // Shift the issue tag one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[MUL_LAT-1];

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: host-loaded float32 buffer cubed in place via two passes through an external multiplier
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int DEPTH   = ACC_DEPTH,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        bsy,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_res
);

    logic [31:0]       buf_q [DEPTH];
    logic [31:0]       sq_q  [DEPTH];
    acc_state_t        state;
    logic [ACC_IW-1:0] idx;
    logic [ACC_IW-1:0] widx;
    logic              host_ok;
    logic              host_wr;
    logic              issuing;
    logic              idx_last;
    logic              drain_last;
    acc_tag_t          tag_in;
    acc_tag_t          tag_out;
    logic              unused_addr_lsb;

    assign widx            = addr[5:2];
    assign host_ok         = (addr[31:6] == '0) && (int'(widx) < DEPTH);
    assign host_wr         = wen && !bsy && host_ok;
    assign issuing         = (state == SQ_ISSUE) || (state == CU_ISSUE);
    assign idx_last        = idx == ACC_IW'(DEPTH - 1);
    assign drain_last      = idx == ACC_IW'(MUL_LAT - 1);
    assign unused_addr_lsb = ^addr[1:0];

    assign tag_in = '{valid: issuing, pass: (state == CU_ISSUE) ? PASS_CU : PASS_SQ, idx: idx};

    acc_tag_pipe #(.MUL_LAT(MUL_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Storage: host writes only while idle, products land where their tag says
    always_ff @(posedge clk) begin
        if (host_wr) buf_q[widx] <= din;
        if (tag_out.valid && tag_out.pass == PASS_SQ) sq_q[tag_out.idx] <= mul_res;
        if (tag_out.valid && tag_out.pass == PASS_CU) buf_q[tag_out.idx] <= mul_res;
    end

    // Host read port, one cycle behind the address; out-of-window reads return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout <= '0;
        else     dout <= host_ok ? buf_q[widx] : '0;
    end

    // Sequencer: square pass, drain, cube pass, drain; idx counts entries or drain cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            bsy       <= 1'b0;
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mul_valid <= 1'b0;
                    idx       <= '0;
                    if (start) begin
                        state <= SQ_ISSUE;
                        bsy   <= 1'b1;
                    end
                end
                SQ_ISSUE: begin
                    mul_valid <= 1'b1;
                    mul_a     <= buf_q[idx];
                    mul_b     <= buf_q[idx];
                    idx       <= idx_last ? '0 : idx + 1'b1;
                    if (idx_last) state <= SQ_DRAIN;
                end
                SQ_DRAIN: begin
                    mul_valid <= 1'b0;
                    idx       <= drain_last ? '0 : idx + 1'b1;
                    if (drain_last) state <= CU_ISSUE;
                end
                CU_ISSUE: begin
                    mul_valid <= 1'b1;
                    mul_a     <= sq_q[idx];
                    mul_b     <= buf_q[idx];
                    idx       <= idx_last ? '0 : idx + 1'b1;
                    if (idx_last) state <= CU_DRAIN;
                end
                CU_DRAIN: begin
                    mul_valid <= 1'b0;
                    idx       <= drain_last ? '0 : idx + 1'b1;
                    if (drain_last) begin
                        state <= IDLE;
                        bsy   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    bsy       <= 1'b0;
                    mul_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed scenarios for the cube sequencer with a behavioural float32 multiplier
module tb_acc_seq_ctrl;

    localparam int DEPTH   = 16;
    localparam int MUL_LAT = 3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        wen   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] din   = '0;
    logic [31:0] dout;
    logic        bsy;
    logic        mul_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_res;

    int n_cmp = 0;
    int n_err = 0;

    // 0.5, 2.0, 3.0 ... 16.0 and their cubes
    logic [31:0] base_v [16] = '{
        32'h3f000000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] cube_v [16] = '{
        32'h3e000000, 32'h41000000, 32'h41d80000, 32'h42800000,
        32'h42fa0000, 32'h43580000, 32'h43ab8000, 32'h44000000,
        32'h44364000, 32'h447a0000, 32'h44a66000, 32'h44d80000,
        32'h45095000, 32'h452b8000, 32'h4552f000, 32'h45800000};

    acc_seq_ctrl #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .start     (start),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .bsy       (bsy),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res)
    );

    always #5 clk = ~clk;

    // Truncating float32 multiply; exact for the small integers and powers of two used here
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    // External multiplier: result seen by the DUT MUL_LAT edges after the issuing edge
    logic [31:0] mp [MUL_LAT-1];
    always @(posedge clk) begin
        mp[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT - 1; i++) mp[i] <= mp[i-1];
    end
    assign mul_res = mp[MUL_LAT-2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base();
        for (int i = 0; i < DEPTH; i++) begin
            wen  = 1'b1;
            addr = 32'(i * 4);
            din  = base_v[i];
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (bsy === 1'b1 && c < 200) begin
            tick();
            c++;
        end
        n_cmp++;
        if (bsy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_timeout: bsy=%b want 0", tag, bsy);
        end
    endtask

    task automatic verify_cubes(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            addr = 32'(i * 4);
            tick();
            n_cmp++;
            if (dout !== cube_v[i]) begin
                n_err++;
                $display("FAIL %s buf[%0d]: got %h want %h", tag, i, dout, cube_v[i]);
            end
        end
    endtask

    task automatic run_measure(input int restart_at, output int nb);
        nb    = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (bsy === 1'b1 && nb < 200) begin
            nb++;
            start = (nb == restart_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (bsy !== 1'b0)       begin n_err++; $display("FAIL reset bsy: got %b want 0", bsy); end
        if (dout !== 32'h0)     begin n_err++; $display("FAIL reset dout: got %h want 0", dout); end
        if (mul_valid !== 1'b0) begin n_err++; $display("FAIL reset mul_valid: got %b want 0", mul_valid); end
        if (mul_a !== 32'h0)    begin n_err++; $display("FAIL reset mul_a: got %h want 0", mul_a); end
        if (mul_b !== 32'h0)    begin n_err++; $display("FAIL reset mul_b: got %h want 0", mul_b); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cube_run();
        int nb;
        load_base();
        run_measure(-1, nb);
        n_cmp++;
        if (nb != 38) begin n_err++; $display("FAIL cube_run bsy_cycles: got %0d want 38", nb); end
        verify_cubes("cube_run");
    endtask

    task automatic test_timing();
        logic bs [45];
        logic mv [45];
        int nb, nm, runs, first, len1, gap, len2;
        load_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 45; c++) begin
            bs[c] = bsy;
            mv[c] = mul_valid;
            tick();
        end
        nb = 0; nm = 0; runs = 0; first = -1; len1 = 0; gap = 0; len2 = 0;
        for (int c = 0; c < 45; c++) begin
            nb += int'(bs[c]);
            nm += int'(mv[c]);
            if (mv[c] && (c > 0 ? !mv[c-1] : 1'b1)) begin
                runs++;
                if (first < 0) first = c;
            end
            if (mv[c] && runs == 1) len1++;
            if (mv[c] && runs == 2) len2++;
            if (!mv[c] && runs == 1) gap++;
        end
        n_cmp += 7;
        if (nb != 38)   begin n_err++; $display("FAIL timing bsy_cycles: got %0d want 38", nb); end
        if (nm != 32)   begin n_err++; $display("FAIL timing mul_valid_cycles: got %0d want 32", nm); end
        if (runs != 2)  begin n_err++; $display("FAIL timing bursts: got %0d want 2", runs); end
        if (first != 1) begin n_err++; $display("FAIL timing first_issue: got %0d want 1", first); end
        if (len1 != 16) begin n_err++; $display("FAIL timing burst1_len: got %0d want 16", len1); end
        if (gap != 3)   begin n_err++; $display("FAIL timing gap: got %0d want 3", gap); end
        if (len2 != 16) begin n_err++; $display("FAIL timing burst2_len: got %0d want 16", len2); end
    endtask

    task automatic test_bad_writes();
        wen  = 1'b1;
        addr = 32'h40;
        din  = 32'hdeadbeef;
        tick();
        addr = 32'h80000000;
        tick();
        wen  = 1'b0;
        addr = 32'h40;
        tick();
        n_cmp++;
        if (dout !== 32'h0) begin n_err++; $display("FAIL bad_write oob_read: got %h want 0", dout); end
        addr = 32'h0;
        tick();
        n_cmp++;
        if (dout !== cube_v[0]) begin n_err++; $display("FAIL bad_write oob_alias buf[0]: got %h want %h", dout, cube_v[0]); end
        load_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        wen  = 1'b1;
        addr = 32'h8;
        din  = 32'hdeadbeef;
        tick();
        wen = 1'b0;
        wait_done("bad_write");
        addr = 32'h8;
        tick();
        n_cmp++;
        if (dout !== cube_v[2]) begin n_err++; $display("FAIL bad_write busy_write buf[2]: got %h want %h", dout, cube_v[2]); end
    endtask

    task automatic test_restart();
        int nb;
        load_base();
        run_measure(10, nb);
        n_cmp++;
        if (nb != 38) begin n_err++; $display("FAIL restart bsy_cycles: got %0d want 38", nb); end
        verify_cubes("restart");
    endtask

    task automatic test_reset_mid();
        int nb;
        load_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        n_cmp += 2;
        if (bsy !== 1'b0)       begin n_err++; $display("FAIL reset_mid bsy: got %b want 0", bsy); end
        if (mul_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid mul_valid: got %b want 0", mul_valid); end
        #1 rst = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < DEPTH; i++) begin
            addr = 32'(i * 4);
            tick();
            n_cmp++;
            if (dout !== base_v[i]) begin
                n_err++;
                $display("FAIL reset_mid untouched buf[%0d]: got %h want %h", i, dout, base_v[i]);
            end
        end
        load_base();
        run_measure(-1, nb);
        n_cmp++;
        if (nb != 38) begin n_err++; $display("FAIL reset_mid rerun bsy_cycles: got %0d want 38", nb); end
        verify_cubes("reset_mid_rerun");
    endtask

    task automatic test_wen_start();
        load_base();
        wen   = 1'b1;
        addr  = 32'h0;
        din   = 32'h40400000;
        start = 1'b1;
        tick();
        wen   = 1'b0;
        start = 1'b0;
        wait_done("wen_start");
        addr = 32'h0;
        tick();
        n_cmp++;
        if (dout !== 32'h41d80000) begin n_err++; $display("FAIL wen_start buf[0]: got %h want 41d80000", dout); end
        addr = 32'h4;
        tick();
        n_cmp++;
        if (dout !== 32'h41000000) begin n_err++; $display("FAIL wen_start buf[1]: got %h want 41000000", dout); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cube_run();
        test_timing();
        test_bad_writes();
        test_restart();
        test_reset_mid();
        test_wen_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_seq_ctrl.md
ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit float32 buffer entries.
REQ-002 SHALL have parameter MUL_LAT, default 3, fixed latency in cycles of the external FP multiplier.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wen, input, 1, host write enable.
REQ-006 SHALL have port start, input, 1, host run request.
REQ-007 SHALL have port addr, input, 32, host byte address; word index is addr[5:2].
REQ-008 SHALL have port din, input, 32, host write data.
REQ-009 SHALL have port dout, output, 32, registered host read data.
REQ-010 SHALL have port bsy, output, 1, run in progress.
REQ-011 SHALL have ports mul_valid (output, 1), mul_a (output, 32) and mul_b (output, 32), registered multiplier issue.
REQ-012 SHALL have port mul_res, input, 32, product valid exactly MUL_LAT cycles after the matching mul_valid cycle.

Function
REQ-013 SHALL hold buf[DEPTH] and scratch sq[DEPTH], each 32-bit, and compute buf[i] <= buf[i]*buf[i]*buf[i] in place per run.
REQ-014 SHALL write din to buf[addr[5:2]] on the clk edge when wen=1, bsy=0 and addr[31:6]=0; otherwise the write is dropped; addr[1:0] is ignored.
REQ-015 SHALL register dout each cycle as buf[addr[5:2]] (1-cycle latency) when addr[31:6]=0, else 0; reads are permitted while bsy=1 and return current contents.
REQ-016 SHALL implement FSM states IDLE, SQ_ISSUE, SQ_DRAIN, CU_ISSUE, CU_DRAIN.
REQ-017 SHALL transition IDLE->SQ_ISSUE on start=1 and set bsy=1 on that edge; start while bsy=1 is ignored.
REQ-018 SHALL in SQ_ISSUE issue one op per cycle for i=0..DEPTH-1 with mul_a=mul_b=buf[i], then go to SQ_DRAIN.
REQ-019 SHALL stay in SQ_DRAIN MUL_LAT cycles, writing each returned mul_res to sq[i], then go to CU_ISSUE.
REQ-020 SHALL in CU_ISSUE issue mul_a=sq[i], mul_b=buf[i] for i=0..DEPTH-1, then go to CU_DRAIN.
REQ-021 SHALL stay in CU_DRAIN MUL_LAT cycles, writing each returned mul_res to buf[i], then go to IDLE.
REQ-022 SHALL track in-flight ops with a MUL_LAT-deep valid/index/pass delay line; writeback uses only this delay line.
REQ-023 SHALL clear bsy on the same edge that performs the final buf writeback; bsy is high for exactly 2*DEPTH+2*MUL_LAT cycles (38 at defaults).
REQ-024 SHALL, when wen=1 and start=1 coincide in IDLE, perform the write and start the run; the written value is included in the run.
REQ-025 SHALL drive mul_valid=0 in IDLE and in both drain states; mul_a/mul_b hold their last value when mul_valid=0.

Reset
REQ-026 SHALL on rst=1, immediately and regardless of clk, set state IDLE, bsy=0, dout=0, mul_valid=0, mul_a=0, mul_b=0, and clear the delay line and the index counter.
REQ-027 SHALL leave buf and sq contents unspecified after reset; rst asserted mid-run abandons the run with no further writebacks.

Structure
REQ-028 SHALL take DEPTH default, the word-index width (log2 DEPTH) and the FSM state encoding from a shared package acc_pkg.
REQ-029 SHALL place the valid/index/pass delay line in one sub-module acc_tag_pipe, parameterised by MUL_LAT; the multiplier stays outside this block.

Verification
REQ-030 SHALL cover: load 0.5, 2.0, ..., 16.0 (0x3f000000, 0x40000000 ... 0x41800000), start -> reads return 0x3e000000, 0x41000000, 0x41d80000 ... 0x45800000.
REQ-031 SHALL cover: start pulse -> bsy high exactly 38 cycles; mul_valid high exactly 32 cycles, in two bursts of 16 separated by 3 idle cycles.
REQ-032 SHALL cover: wen=1 with addr=0x40 or with bsy=1 -> buf unchanged; dout for addr=0x40 reads 0.
REQ-033 SHALL cover: start asserted again at cycle 10 of a run -> ignored, bsy still drops after 38 cycles with correct results.
REQ-034 SHALL cover: rst pulsed mid-run at cycle 20 -> bsy=0 and mul_valid=0 immediately; no buf write occurs in the following 10 cycles; a new run after reloading passes REQ-030.
REQ-035 SHALL cover: wen=1 (addr=0, din=0x40400000) together with start=1 -> buf[0] reads 0x41d80000 after the run.
